// File: rtl/serial_add8.sv
// Bit-serial 8-bit adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/a/b/cin in; busy, done, sum, cout
// out; ovf out only when SERIAL_ADD8_OVF_EN is defined.
module serial_add8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum,
  output logic       cout
`ifdef SERIAL_ADD8_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       load;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [6:0] s_sh;
  logic       carry;
  logic [2:0] cnt;
  logic       s;
  logic       c;
  logic       last;

  // Single full-adder cell on the current LSBs.
  assign s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load = 1'b1;
          nxt  = S_RUN;
        end else begin
          nxt  = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD8_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh  <= {1'b0, a_sh[7:1]};
      b_sh  <= {1'b0, b_sh[7:1]};
      s_sh  <= {s, s_sh[6:1]};
      carry <= c;
      cnt   <= cnt + 3'd1;
      if (last) begin
        // s_sh already holds bits 0..6; s is bit 7.
        sum  <= {s, s_sh};
        cout <= c;
`ifdef SERIAL_ADD8_OVF_EN
        // On the last bit, a_sh[0]/b_sh[0] are the latched a[7]/b[7].
        ovf  <= (a_sh[0] == b_sh[0]) && (s != a_sh[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add8.sv
// Scoreboard bench for serial_add8: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add8;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];

  serial_add8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADD8_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

`ifndef SERIAL_ADD8_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef SERIAL_ADD8_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one start for a single cycle; returns at the negedge after
  // the accepting edge.
  task automatic go(input logic [7:0] ia, input logic [7:0] ib,
                    input logic ic, input bit push,
                    input logic [7:0] es, input logic ec,
                    input logic eo);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    if (push) q.push_back('{es, ec, eo, cyc + 9});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    int nb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sum", {24'd0, sum}, 32'h00);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    go(8'h3C, 8'h55, 1'b0, 1'b1, 8'h91, 1'b0, 1'b1);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) nb++;
      if (i == 4) chk("sum_hold_run", {24'd0, sum}, 32'h00);
      @(negedge clk);
    end
    chk("busy_cycles", nb, 32'd8);
    drain();

    go(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();
    go(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain();

    go(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'h7F;
    b     = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    chk("ignored_sum", {24'd0, sum}, 32'h30);
    chk("ignored_busy", {31'd0, busy}, 32'd0);

    go(8'h01, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'h00);
    @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    go(8'h05, 8'h06, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    drain();

    @(negedge clk);
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    q.push_back('{8'h00, 1'b1, 1'b1, cyc + 9});
    repeat (9) @(negedge clk);
    chk("b2b_done", {31'd0, done}, 32'd1);
    a = 8'h01;
    b = 8'h01;
    q.push_back('{8'h02, 1'b0, 1'b0, cyc + 9});
    @(negedge clk);
    start = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    chk("final_queue", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
